// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: address decode shared by the fetch and load paths of instr_mem_pipe.
package instr_mem_pkg;

  function automatic logic [63:0] addr_idx(input logic [63:0] addr, input logic byte_addr);
    return byte_addr ? addr >> 2 : addr;
  endfunction

  function automatic logic addr_err(input logic [63:0] addr, input int depth, input logic byte_addr);
    return addr_idx(addr, byte_addr) >= 64'(depth) || (byte_addr && addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// rsp_fifo: response buffer with async reset and a synchronous clear used for flush.
module rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q, wp_d, rp_d;
  logic [CW-1:0] cnt_q;
  logic          do_pop, full;
  assign empty  = cnt_q == '0;
  assign full   = cnt_q == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign dout   = empty ? '0 : mem_q[rp_q];
  assign wp_d   = wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1;
  assign rp_d   = rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_d;
      if (do_pop) rp_q <= rp_d;
      cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (push && !clr) mem_q[wp_q] <= din;
  // Credit limit upstream guarantees a push never meets a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !clr && full));
endmodule

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: fetch-stage instruction memory with a LATENCY-cycle read pipeline,
// credit-based backpressure, flush, address error reporting and a run-time load port.
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 256,
  parameter int    ADDR_W    = 32,
  parameter int    LATENCY   = 1,
  parameter int    BYTE_ADDR = 0,
  parameter string INIT_FILE = "FILENAME.mem"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CAP   = LATENCY + 1;
  localparam int CNT_W = $clog2(CAP + 1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              req_err, load_err, acc, pop, push, empty;
  logic [IDX_W-1:0]  req_idx, load_idx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W:0]   push_data, head;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  assign req_err   = addr_err(64'(req_addr), DEPTH, BYTE_ADDR != 0);
  assign load_err  = addr_err(64'(load_addr), DEPTH, BYTE_ADDR != 0);
  assign req_idx   = IDX_W'(addr_idx(64'(req_addr), BYTE_ADDR != 0));
  assign load_idx  = IDX_W'(addr_idx(64'(load_addr), BYTE_ADDR != 0));
  assign req_ready = rst_n && !load_en && !flush && cnt_q < CNT_W'(CAP);
  assign acc       = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign rd_data   = req_err ? '0 : mem_q[req_idx];
  assign cnt_d     = flush ? '0 : cnt_q + CNT_W'(acc) - CNT_W'(pop);
  assign rsp_valid = !empty;
  assign {rsp_err, rsp_instr} = head;
  always_ff @(posedge clk)
    if (load_en && !load_err) mem_q[load_idx] <= load_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // The array read happens on accept; the last pipeline step is the FIFO write itself.
  if (LATENCY == 1) begin : g_direct
    assign push      = acc;
    assign push_data = {req_err, rd_data};
  end else begin : g_pipe
    localparam int S = LATENCY - 1;
    logic [S-1:0]  v_q;
    logic [DATA_W:0] d_q [S];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) v_q <= '0;
      else if (flush) v_q <= '0;
      else begin
        v_q[0] <= acc;
        for (int i = 1; i < S; i++) v_q[i] <= v_q[i-1];
      end
    always_ff @(posedge clk) begin
      d_q[0] <= {req_err, rd_data};
      for (int i = 1; i < S; i++) d_q[i] <= d_q[i-1];
    end
    assign push      = v_q[S-1];
    assign push_data = d_q[S-1];
  end
  rsp_fifo #(.W(DATA_W + 1), .DEPTH(CAP)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .din   (push_data),
    .pop   (rsp_ready),
    .dout  (head),
    .empty (empty)
  );
endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb_instr_mem_pipe: directed and random fetch/load/flush traffic checked against a queue-based model.
module tb_instr_mem_pipe;
  localparam int L     = 2;
  localparam int CAP   = L + 1;
  localparam int DEPTH = 256;
  logic        clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 0, flush = 0, load_en = 0;
  logic [31:0] req_addr = 0, load_addr = 0, load_data = 0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_instr;
  int          vec = 0, miss = 0, edges = 0;
  typedef struct { logic [31:0] data; logic err; int due; } item_t;
  item_t       q[$];
  logic [31:0] mref [DEPTH];

  instr_mem_pipe #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LATENCY(L), .BYTE_ADDR(1), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  function automatic logic bad(input logic [31:0] a);
    return (a >> 2) >= 32'(DEPTH) || a[1:0] != 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check visible outputs against the model, then advance the model at the edge.
  task automatic step(input logic rv, input logic [31:0] a, input logic rr, input logic fl,
                      input logic le, input logic [31:0] la, input logic [31:0] ld);
    logic er, ev, acc, pop;
    req_valid = rv; req_addr = a; rsp_ready = rr; flush = fl;
    load_en = le; load_addr = la; load_data = ld;
    #1;
    er = !le && !fl && q.size() < CAP;
    ev = q.size() > 0 && q[0].due <= edges;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk("rsp_instr", rsp_instr, q[0].data);
      chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
    end
    acc = rv && er;
    pop = ev && rr;
    @(posedge clk);
    edges++;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{bad(a) ? 32'h0 : mref[a >> 2], bad(a), edges + L - 1});
    end
    if (le && !bad(la)) mref[la >> 2] = ld;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    step(1'b1, a, rr, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] la, input logic [31:0] ld);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, la, ld);
  endtask

  initial begin
    req_valid = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_instr", rsp_instr, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    req_valid = 0;
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) load(32'(i * 4), $urandom);
    load(32'd20, 32'hDEADBEEF);
    fetch(32'd20, 1'b1);
    idle(3);
    for (int i = 0; i < 10; i++) fetch(32'(i * 4), 1'b1);
    idle(4);
    for (int i = 0; i < 6; i++) fetch(32'(i * 4 + 40), 1'b0);
    idle(6);
    fetch(32'h0000_0402, 1'b1);
    fetch(32'h0000_0400, 1'b1);
    fetch(32'h0000_03FC, 1'b1);
    idle(3);
    step(1'b1, 32'd28, 1'b1, 1'b0, 1'b1, 32'd28, 32'h1234_5678);
    fetch(32'd28, 1'b1);
    idle(3);
    for (int i = 0; i < 3; i++) fetch(32'(i * 4 + 100), 1'b0);
    step(1'b1, 32'd8, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(4);
    for (int i = 0; i < 400; i++) begin
      int          r;
      logic [31:0] a, la;
      r  = 32'($urandom_range(0, 9));
      a  = r < 7 ? {22'h0, 8'($urandom_range(0, 255)), 2'b00}
         : r == 7 ? {22'h0, 8'($urandom_range(0, 255)), 2'b01}
         : r == 8 ? 32'h400 + $urandom_range(0, 4000) : $urandom;
      la = r == 9 ? $urandom : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      step(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 19) == 0), la, $urandom);
    end
    idle(4);
    for (int i = 0; i < 3; i++) fetch(32'(i * 4 + 200), 1'b0);
    req_valid = 0; rsp_ready = 0; flush = 0; load_en = 0;
    #2 rst_n = 0;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("async_rst_rsp_instr", rsp_instr, 32'h0);
    chk("async_rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("async_rst_req_ready", 32'(req_ready), 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    fetch(32'd20, 1'b1);
    fetch(32'd28, 1'b1);
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
